// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the CPU HALT/SLP sequencing logic.
//   halt_state_t : execution state of the halt/sleep controller
//   OP_HALT      : HALT opcode, decoded to raise halt_req
//   OP_SLP       : SLP opcode, decoded to raise sleep_req
//   wake_load()  : converts a WAKE duration in ticks into the counter preload
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } halt_state_t;

    localparam logic [11:0] OP_HALT = 12'hFF8;
    localparam logic [11:0] OP_SLP  = 12'hFF9;

    // WAKE lasts 'ticks' clk_en ticks; the counter reaching zero ends it,
    // so the preload is one less than the duration.
    function automatic logic [7:0] wake_load(input int ticks);
        return 8'(ticks - 1);
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// -----------------------------------------------------------------------------
// tick_down_counter
// 8-bit loadable down-counter that only advances on clk_en ticks.
// Ports:
//   i_clk      : system clock
//   i_reset_n  : synchronous active-low reset, clears the count
//   i_clk_en   : tick qualifier; load/decrement happen only when high
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_count    : current count
//   o_is_zero  : count equals zero
// -----------------------------------------------------------------------------
module tick_down_counter (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clk_en,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic [7:0] o_count,
    output logic       o_is_zero
);

    logic [7:0] r_count;

    // Count register: load wins over decrement; reset ignores clk_en.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= 8'd0;
        end else if (i_clk_en) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = (r_count == 8'd0);

endmodule

// File: rtl/cpu_halt_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_halt_sleep_ctrl
// Gates the CPU step enable around HALT and SLP, requests OSC1 stop while
// sleeping and releases the core after an interrupt plus a wake delay.
// Ports:
//   i_clk           : system clock
//   i_reset_n       : synchronous active-low reset
//   i_clk_en        : base CPU tick; state only advances when high
//   i_halt_req      : HALT retired (one tick pulse)
//   i_sleep_req     : SLP retired (one tick pulse)
//   i_irq_pending   : any enabled interrupt pending (wakes HALT)
//   i_irq_k_pending : K-port interrupt pending (only source that wakes SLEEP)
//   o_cpu_step_en   : clk_en gated by state==RUN
//   o_halted        : in HALT
//   o_sleeping      : in SLEEP
//   o_osc1_stop     : in SLEEP or in the WAKE following SLEEP
//   o_wake_pulse    : high for the WAKE tick that returns to RUN
// -----------------------------------------------------------------------------
module cpu_halt_sleep_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int SLP_WAKE_TICKS  = 8,
    parameter int HALT_WAKE_TICKS = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clk_en,
    input  logic i_halt_req,
    input  logic i_sleep_req,
    input  logic i_irq_pending,
    input  logic i_irq_k_pending,
    output logic o_cpu_step_en,
    output logic o_halted,
    output logic o_sleeping,
    output logic o_osc1_stop,
    output logic o_wake_pulse
);

    localparam logic [7:0] SLP_LOAD  = wake_load(SLP_WAKE_TICKS);
    localparam logic [7:0] HALT_LOAD = wake_load(HALT_WAKE_TICKS);

    halt_state_t r_state;
    halt_state_t w_next_state;
    logic        r_halted;
    logic        r_sleeping;
    logic        r_from_sleep;
    logic        r_wake_pulse;

    logic        w_load;
    logic [7:0]  w_load_val;
    logic        w_dec;
    logic [7:0]  w_count;
    logic        w_is_zero;
    logic        w_next_zero;

    tick_down_counter u_wake_cnt (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clk_en   (i_clk_en),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_is_zero  (w_is_zero)
    );

    // Next-state and wake-counter control for the coming tick.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 8'd0;
        w_dec        = 1'b0;
        w_next_zero  = 1'b0;
        case (r_state)
            RUN: begin
                // SLP has priority when both instructions report at once.
                if (i_sleep_req) begin
                    w_next_state = SLEEP;
                end else if (i_halt_req) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = RUN;
                end
            end
            HALT: begin
                if (i_irq_pending) begin
                    w_next_state = WAKE;
                    w_load       = 1'b1;
                    w_load_val   = HALT_LOAD;
                end else begin
                    w_next_state = HALT;
                end
            end
            SLEEP: begin
                // Only K-port inputs can wake the core with OSC1 stopped.
                if (i_irq_k_pending) begin
                    w_next_state = WAKE;
                    w_load       = 1'b1;
                    w_load_val   = SLP_LOAD;
                end else begin
                    w_next_state = SLEEP;
                end
            end
            WAKE: begin
                if (w_is_zero) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = WAKE;
                    w_dec        = 1'b1;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase

        // Counter value after this tick; a zero in WAKE marks the final tick.
        if (w_load) begin
            w_next_zero = (w_load_val == 8'd0);
        end else if (w_dec) begin
            w_next_zero = (w_count == 8'd1);
        end else begin
            w_next_zero = w_is_zero;
        end
    end

    // State register with registered status outputs, advanced per tick.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= RUN;
            r_halted     <= 1'b0;
            r_sleeping   <= 1'b0;
            r_from_sleep <= 1'b0;
            r_wake_pulse <= 1'b0;
        end else if (i_clk_en) begin
            r_state      <= w_next_state;
            r_halted     <= (w_next_state == HALT);
            r_sleeping   <= (w_next_state == SLEEP);
            // Oscillator stays stopped through the WAKE that follows SLEEP.
            r_from_sleep <= (w_next_state == SLEEP) ||
                            ((w_next_state == WAKE) && r_from_sleep);
            r_wake_pulse <= (w_next_state == WAKE) && w_next_zero;
        end else begin
            r_state      <= r_state;
            r_halted     <= r_halted;
            r_sleeping   <= r_sleeping;
            r_from_sleep <= r_from_sleep;
            r_wake_pulse <= r_wake_pulse;
        end
    end

    assign o_cpu_step_en = i_clk_en & (r_state == RUN);
    assign o_halted      = r_halted;
    assign o_sleeping    = r_sleeping;
    assign o_osc1_stop   = r_from_sleep;
    assign o_wake_pulse  = r_wake_pulse;

endmodule

// File: tb/tb_cpu_halt_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_halt_sleep_ctrl
// Directed scenarios and a randomized run against a tick-level reference
// model of the HALT/SLP sequencing rules.
// Output vectors are packed as {step_en, halted, sleeping, osc1_stop, wake}.
// -----------------------------------------------------------------------------
module tb_cpu_halt_sleep_ctrl;

    localparam int SLP_T  = 8;
    localparam int HALT_T = 1;

    localparam int M_RUN   = 0;
    localparam int M_HALT  = 1;
    localparam int M_SLEEP = 2;
    localparam int M_WAKE  = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic clk_en;
    logic halt_req;
    logic sleep_req;
    logic irq_pending;
    logic irq_k_pending;
    logic cpu_step_en;
    logic halted;
    logic sleeping;
    logic osc1_stop;
    logic wake_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus number of WAKE ticks still to be spent.
    int m_mode;
    int m_left;
    bit m_from_sleep;

    logic [4:0] exp_v;
    logic [4:0] act_v;
    logic [4:0] idle_exp;
    logic [4:0] idle_act;

    always #5 clk = ~clk;

    cpu_halt_sleep_ctrl #(
        .SLP_WAKE_TICKS  (SLP_T),
        .HALT_WAKE_TICKS (HALT_T)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_clk_en        (clk_en),
        .i_halt_req      (halt_req),
        .i_sleep_req     (sleep_req),
        .i_irq_pending   (irq_pending),
        .i_irq_k_pending (irq_k_pending),
        .o_cpu_step_en   (cpu_step_en),
        .o_halted        (halted),
        .o_sleeping      (sleeping),
        .o_osc1_stop     (osc1_stop),
        .o_wake_pulse    (wake_pulse)
    );

    task automatic model_step(input logic rn, en, hr, sr, irq, irqk);
        if (!rn) begin
            m_mode = M_RUN; m_left = 0; m_from_sleep = 1'b0;
        end else if (en) begin
            case (m_mode)
                M_RUN: begin
                    if (sr) begin m_mode = M_SLEEP; m_from_sleep = 1'b1; end
                    else if (hr) begin m_mode = M_HALT; m_from_sleep = 1'b0; end
                end
                M_HALT:  if (irq)  begin m_mode = M_WAKE; m_left = HALT_T; end
                M_SLEEP: if (irqk) begin m_mode = M_WAKE; m_left = SLP_T; end
                default: begin
                    if (m_left <= 1) begin
                        m_mode = M_RUN; m_left = 0; m_from_sleep = 1'b0;
                    end else begin
                        m_left = m_left - 1;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive at negedge, capture DUT and model outputs, advance model.
    task automatic cyc(input logic rn, en, hr, sr, irq, irqk);
        @(negedge clk);
        reset_n = rn; clk_en = en; halt_req = hr; sleep_req = sr;
        irq_pending = irq; irq_k_pending = irqk;
        #1;
        exp_v = {en & (m_mode == M_RUN), m_mode == M_HALT, m_mode == M_SLEEP,
                 (m_mode == M_SLEEP) || ((m_mode == M_WAKE) && m_from_sleep),
                 (m_mode == M_WAKE) && (m_left == 1)};
        act_v = {cpu_step_en, halted, sleeping, osc1_stop, wake_pulse};
        model_step(rn, en, hr, sr, irq, irqk);
    endtask

    // One clk_en tick with the divider running at every second clock.
    task automatic tick(input logic hr, sr, irq, irqk);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, irq, irqk);
        idle_exp = exp_v;
        idle_act = act_v;
        cyc(1'b1, 1'b1, hr, sr, irq, irqk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (idle_act !== 5'b00000) begin
                errors++;
                $display("FAIL reset_idle t=%0d got %b want %b", t, idle_act, 5'b00000);
            end
            checks++;
            if (act_v !== 5'b10000) begin
                errors++;
                $display("FAIL reset_tick t=%0d got %b want %b", t, act_v, 5'b10000);
            end
        end
    endtask

    task automatic test_halt();
        logic [4:0] want;
        do_reset();
        for (int t = 1; t <= 24; t++) begin
            tick(t == 10, 1'b0, (t >= 20) && (t <= 22), 1'b0);
            want = {!((t >= 11) && (t <= 21)), (t >= 11) && (t <= 20), 1'b0, 1'b0, t == 21};
            checks++;
            if (act_v !== want) begin
                errors++;
                $display("FAIL halt t=%0d got %b want %b", t, act_v, want);
            end
            checks++;
            if (idle_act !== idle_exp) begin
                errors++;
                $display("FAIL halt_idle t=%0d got %b want %b", t, idle_act, idle_exp);
            end
        end
    endtask

    task automatic test_sleep();
        logic [4:0] want;
        do_reset();
        // halt/sleep pulses at ticks 15/16 fall inside WAKE and must be ignored.
        for (int t = 1; t <= 23; t++) begin
            tick(t == 15, (t == 5) || (t == 16), t == 8, t == 12);
            want = {(t <= 5) || (t >= 21), 1'b0, (t >= 6) && (t <= 12),
                    (t >= 6) && (t <= 20), t == 20};
            checks++;
            if (act_v !== want) begin
                errors++;
                $display("FAIL sleep t=%0d got %b want %b", t, act_v, want);
            end
        end
    endtask

    task automatic test_both_req();
        logic [4:0] want;
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            tick(t == 3, t == 3, 1'b0, t == 6);
            want = {(t <= 3) || (t >= 15), 1'b0, (t >= 4) && (t <= 6),
                    (t >= 4) && (t <= 14), t == 14};
            checks++;
            if (act_v !== want) begin
                errors++;
                $display("FAIL both_req t=%0d got %b want %b", t, act_v, want);
            end
        end
    endtask

    task automatic test_step_gap();
        logic [4:0] want;
        int suppressed;
        suppressed = 0;
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            tick(t == 4, 1'b0, 1'b1, 1'b0);
            if (act_v[4] == 1'b0) suppressed++;
            want = {!((t == 5) || (t == 6)), t == 5, 1'b0, 1'b0, t == 6};
            checks++;
            if (act_v !== want) begin
                errors++;
                $display("FAIL step_gap t=%0d got %b want %b", t, act_v, want);
            end
        end
        checks++;
        if (suppressed != 2) begin
            errors++;
            $display("FAIL step_gap_count got %0d want %0d", suppressed, 2);
        end
    endtask

    task automatic test_reset_in_wake();
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        // Now in WAKE with five ticks of count left; reset with clk_en low.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_v !== 5'b00010) begin
            errors++;
            $display("FAIL wake_before_reset got %b want %b", act_v, 5'b00010);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_v !== 5'b00000) begin
            errors++;
            $display("FAIL wake_after_reset got %b want %b", act_v, 5'b00000);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_v !== 5'b10000) begin
            errors++;
            $display("FAIL wake_reset_step got %b want %b", act_v, 5'b10000);
        end
    endtask

    task automatic test_random();
        logic en, rn, hr, sr;
        logic irq_lvl, irqk_lvl;
        irq_lvl  = 1'b0;
        irqk_lvl = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 299) != 0);
            hr = en & ($urandom_range(0, 7) == 0);
            sr = en & ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0)  irq_lvl  = ~irq_lvl;
            if ($urandom_range(0, 14) == 0) irqk_lvl = ~irqk_lvl;
            cyc(rn, en, hr, sr, irq_lvl, irqk_lvl);
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random i=%0d got %b want %b", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; clk_en = 1'b0; halt_req = 1'b0; sleep_req = 1'b0;
        irq_pending = 1'b0; irq_k_pending = 1'b0;
        m_mode = M_RUN; m_left = 0; m_from_sleep = 1'b0;
        test_reset();
        test_halt();
        test_sleep();
        test_both_req();
        test_step_gap();
        test_reset_in_wake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
